// File: rtl/keypad_scan_pkg.sv
// Shared key codes, FSM encoding and the row/column-to-code map for the keypad scanner.
package keypad_scan_pkg;

  localparam logic [4:0] KEY_NONE   = 5'h1F;
  localparam logic [4:0] KEY_RESET  = 5'h1E;
  localparam logic [4:0] KEY_START  = 5'h1C;
  localparam logic [4:0] KEY_TIMING = 5'h18;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    HELD         = 2'd2,
    RELEASE_WAIT = 2'd3
  } state_t;

  typedef struct packed {
    logic       mapped;
    logic [4:0] code;
  } key_ent_t;

  // index = row*4 + col; '*', '#' and 'D' are unmapped so they never count as a press
  function automatic key_ent_t key_map(input logic [3:0] index);
    key_ent_t e;
    e.mapped = 1'b1;
    e.code   = KEY_NONE;
    case (index)
      4'd0:    e.code = 5'h01;
      4'd1:    e.code = 5'h02;
      4'd2:    e.code = 5'h03;
      4'd3:    e.code = KEY_RESET;
      4'd4:    e.code = 5'h04;
      4'd5:    e.code = 5'h05;
      4'd6:    e.code = 5'h06;
      4'd7:    e.code = KEY_START;
      4'd8:    e.code = 5'h07;
      4'd9:    e.code = 5'h08;
      4'd10:   e.code = 5'h09;
      4'd11:   e.code = KEY_TIMING;
      4'd13:   e.code = 5'h00;
      default: e.mapped = 1'b0;
    endcase
    return e;
  endfunction

  function automatic logic mapped_of(input logic [3:0] index);
    key_ent_t e;
    e = key_map(index);
    return e.mapped;
  endfunction

  function automatic logic [4:0] code_of(input logic [3:0] index);
    key_ent_t e;
    e = key_map(index);
    return e.code;
  endfunction

endpackage

// File: rtl/keypad_scan_if.sv
// Pin-side and entry-stage signals of the keypad scanner; master = scanner, slave = board/consumer.
interface keypad_scan_if;
  logic [3:0] col_n;
  logic [3:0] row_n;
  logic [4:0] key_code;
  logic       key_valid;
  logic       beep;

  modport master (input col_n, output row_n, output key_code, output key_valid, output beep);
  modport slave  (output col_n, input row_n, input key_code, input key_valid, input beep);
endinterface

// File: rtl/keypad_sync.sv
// Two-flop synchroniser for the asynchronous active-low keypad columns.
module keypad_sync (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] d,
  output logic [3:0] q
);

  logic [3:0] meta;

  // Idle columns are pulled high, so reset to "no column active"
  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= 4'hF;
      q    <= 4'hF;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/keypad_scan.sv
// 4x4 keypad scanner with scan-level debounce; key_code is a level, key_valid pulses on acceptance.
// Optional buzzer pulse after each accepted key when KEY_BEEP_EN is defined.
module keypad_scan
  import keypad_scan_pkg::*;
#(
  parameter int SCAN_DIV  = 50000,
  parameter int DEB_SCANS = 5,
  parameter int BEEP_CYC  = 5000000
) (
  input  logic          clk,
  input  logic          rst,
  keypad_scan_if.master kp
);

  localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int CW = $clog2(DEB_SCANS + 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] DEB_LAST = CW'(DEB_SCANS);

  logic [3:0]    col_s;
  logic [DW-1:0] div_cnt;
  logic [1:0]    row;
  logic [15:0]   press;
  logic [15:0]   press_now;
  logic [15:0]   hit;
  logic [4:0]    n_hit;
  logic [3:0]    hit_idx;
  logic          slot_end;
  logic          scan_end;
  logic          one_key;
  logic          cand_hit;
  logic          only_cand;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt, cnt_inc;
  logic [3:0]    cand, cand_nxt;
  logic          accept;
  logic          release_done;
  logic [4:0]    accept_code;
  logic [4:0]    key_code_q;
  logic          key_valid_q;

  keypad_sync u_sync (
    .clk (clk),
    .rst (rst),
    .d   (kp.col_n),
    .q   (col_s)
  );

  assign slot_end = (div_cnt == DIV_LAST);
  assign scan_end = slot_end && (row == 2'd3);

  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt <= '0;
      row     <= 2'd0;
      press   <= '0;
    end else if (slot_end) begin
      div_cnt                 <= '0;
      row                     <= row + 2'd1;
      press[{row, 2'b00} +: 4] <= ~col_s;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  assign kp.row_n = ~(4'b0001 << row);

  // At scan end row 3 is being captured this very edge, so classify with the live columns for it
  always_comb begin
    press_now        = press;
    press_now[15:12] = ~col_s;
    hit              = '0;
    n_hit            = '0;
    hit_idx          = '0;
    for (int i = 0; i < 16; i++) begin
      hit[i] = press_now[i] & mapped_of(4'(i));
      n_hit  = n_hit + {4'b0000, hit[i]};
      if (hit[i]) hit_idx = 4'(i);
    end
  end

  assign one_key   = (n_hit == 5'd1);
  assign cand_hit  = hit[cand];
  assign only_cand = one_key && cand_hit;
  assign cnt_inc   = cnt + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      cand  <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      cand  <= cand_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    cand_nxt  = cand;
    if (scan_end) begin
      case (state)
        IDLE: begin
          if (one_key) begin
            cand_nxt = hit_idx;
            if (DEB_SCANS == 1) begin
              state_nxt = HELD;
              cnt_nxt   = '0;
            end else begin
              state_nxt = PRESS_WAIT;
              cnt_nxt   = CW'(1);
            end
          end
        end
        PRESS_WAIT: begin
          if (!only_cand) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
          end else if (cnt_inc == DEB_LAST) begin
            state_nxt = HELD;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt_inc;
          end
        end
        HELD: begin
          // Extra keys alongside the held one do not disturb it
          if (!cand_hit) begin
            if (DEB_SCANS == 1) begin
              state_nxt = IDLE;
              cnt_nxt   = '0;
            end else begin
              state_nxt = RELEASE_WAIT;
              cnt_nxt   = CW'(1);
            end
          end
        end
        RELEASE_WAIT: begin
          if (cand_hit) begin
            state_nxt = HELD;
            cnt_nxt   = '0;
          end else if (cnt_inc == DEB_LAST) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt_inc;
          end
        end
        default: begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end
      endcase
    end
  end

  always_comb begin
    accept       = scan_end && (state_nxt == HELD) &&
                   ((state == IDLE) || (state == PRESS_WAIT));
    release_done = scan_end && (state_nxt == IDLE) &&
                   ((state == HELD) || (state == RELEASE_WAIT));
    accept_code  = code_of(cand_nxt);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      key_code_q  <= KEY_NONE;
      key_valid_q <= 1'b0;
    end else begin
      key_valid_q <= accept;
      if (accept) begin
        key_code_q <= accept_code;
      end else if (release_done) begin
        key_code_q <= KEY_NONE;
      end
    end
  end

  assign kp.key_code  = key_code_q;
  assign kp.key_valid = key_valid_q;

`ifdef KEY_BEEP_EN
  localparam int BW = $clog2(BEEP_CYC + 1);

  logic [BW-1:0] beep_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      beep_cnt <= '0;
    end else if (key_valid_q) begin
      beep_cnt <= BW'(BEEP_CYC);
    end else if (beep_cnt != '0) begin
      beep_cnt <= beep_cnt - 1'b1;
    end
  end

  assign kp.beep = (beep_cnt != '0);
`else
  // BEEP_CYC has no effect without the buzzer
  logic unused_beep_cyc;
  assign unused_beep_cyc = ^BEEP_CYC;
  assign kp.beep         = 1'b0;
`endif

endmodule

// File: tb/tb_keypad_scan.sv
// Keypad scanner bench: a key-matrix model drives the columns, a scoreboard checks code events and beep.
module tb_keypad_scan;

  localparam int SCAN = 16;
  localparam int BEEP = 10;

  typedef struct {
    logic       pulse;
    logic [4:0] code;
    int         at;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] keys = '0;
  logic [3:0]  col_n;
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;
  exp_t        sb[$];

  always #5 clk = ~clk;

  keypad_scan_if kif ();

  keypad_scan #(
    .SCAN_DIV  (4),
    .DEB_SCANS (3),
    .BEEP_CYC  (BEEP)
  ) dut (
    .clk (clk),
    .rst (rst),
    .kp  (kif)
  );

  // A pressed key shorts its row to its column
  always_comb begin
    col_n = 4'hF;
    for (int r = 0; r < 4; r++)
      if (!kif.row_n[r])
        for (int c = 0; c < 4; c++)
          if (keys[r*4+c]) col_n[c] = 1'b0;
  end
  assign kif.col_n = col_n;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // Monitor: every key_valid or key_code change is one scoreboard event
  logic [4:0] last_code = 5'h1F;
  int         bcnt = 0;
  logic       exp_beep;
  exp_t       e;

  always @(negedge clk) begin
    if (rst) begin
      last_code = 5'h1F;
      bcnt      = 0;
    end else begin
      if (kif.key_valid === 1'b1 || kif.key_code !== last_code) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_event: valid=%0b code=%h at cyc %0d, expected no event",
                   kif.key_valid, kif.key_code, cyc);
        end else begin
          e = sb.pop_front();
          if (kif.key_valid !== e.pulse || kif.key_code !== e.code || (e.at >= 0 && cyc != e.at)) begin
            errors++;
            $display("FAIL key_event: valid=%0b code=%h cyc=%0d, expected valid=%0b code=%h cyc=%0d",
                     kif.key_valid, kif.key_code, cyc, e.pulse, e.code, e.at);
          end
        end
      end
      last_code = kif.key_code;
`ifdef KEY_BEEP_EN
      exp_beep = (bcnt > 0);
`else
      exp_beep = 1'b0;
`endif
      checks++;
      if (kif.beep !== exp_beep) begin
        errors++;
        $display("FAIL beep: got %0b at cyc %0d, expected %0b", kif.beep, cyc, exp_beep);
      end
      if (bcnt > 0) bcnt--;
      if (kif.key_valid === 1'b1) bcnt = BEEP;
    end
  end

  // Caller is #1 after a posedge; returns #1 after the last posedge of the hold
  task automatic hold(input logic [15:0] k, input int scans);
    keys = k;
    repeat (scans * SCAN) @(posedge clk);
    #1;
  endtask

  // Return #1 after the posedge on which row 0 starts a new scan
  task automatic align();
    logic [3:0] prev;
    bit         ok;
    ok = 0;
    for (int i = 0; i < 40 && !ok; i++) begin
      prev = kif.row_n;
      @(posedge clk);
      #1;
      if (prev == 4'b0111 && kif.row_n == 4'b1110) ok = 1;
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL align: row_n=%b, expected a 0111->1110 wrap within 40 cycles", kif.row_n);
    end
  endtask

  int          c0;
  logic [3:0]  row_exp [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
  logic [15:0] kmask   [3] = '{16'h0008, 16'h0080, 16'h0800};
  logic [4:0]  kcode   [3] = '{5'h1E, 5'h1C, 5'h18};

  initial begin
    // 1. reset values and row walk
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_row_n", kif.row_n, 4'b1110);
    check_eq("rst_key_code", kif.key_code, 5'h1F);
    check_eq("rst_key_valid", kif.key_valid, 1'b0);
    check_eq("rst_beep", kif.beep, 1'b0);
    rst = 1'b0;
    for (int k = 0; k < 8; k++) begin
      check_eq($sformatf("row_walk_%0d", k), kif.row_n, row_exp[k % 4]);
      repeat (4) @(posedge clk);
      #1;
    end

    // 2. '5' held 8 scans: accept at 3rd scan end, release after 3 empty scans
    align();
    c0 = cyc;
    sb.push_back('{1'b1, 5'h05, c0 + 48});
    hold(16'h0020, 8);
    sb.push_back('{1'b0, 5'h1F, c0 + 176});
    hold(16'h0000, 5);
    check_eq("t2_drain", sb.size(), 0);

    // 3. '7' on alternate scans never debounces
    align();
    for (int k = 0; k < 5; k++) begin
      hold(16'h0100, 1);
      hold(16'h0000, 1);
    end
    hold(16'h0000, 2);
    check_eq("t3_code", kif.key_code, 5'h1F);

    // 4. A, B, C map to command codes; '#' is ignored
    for (int k = 0; k < 3; k++) begin
      sb.push_back('{1'b1, kcode[k], -1});
      hold(kmask[k], 5);
      sb.push_back('{1'b0, 5'h1F, -1});
      hold(16'h0000, 5);
    end
    hold(16'h4000, 5);
    hold(16'h0000, 5);
    check_eq("t4_drain", sb.size(), 0);

    // 5. two keys from idle are ignored; a second key added while held changes nothing
    hold(16'h0003, 5);
    hold(16'h0000, 2);
    check_eq("t5_multi_code", kif.key_code, 5'h1F);
    sb.push_back('{1'b1, 5'h03, -1});
    hold(16'h0004, 5);
    hold(16'h0044, 4);
    check_eq("t5_held_code", kif.key_code, 5'h03);
    sb.push_back('{1'b0, 5'h1F, -1});
    hold(16'h0000, 5);
    check_eq("t5_drain", sb.size(), 0);

    // Debounce boundary: 2 scans never accept or release, 3 do
    align();
    hold(16'h0200, 2);
    hold(16'h0000, 3);
    sb.push_back('{1'b1, 5'h08, -1});
    hold(16'h0200, 5);
    align();
    hold(16'h0000, 2);
    hold(16'h0200, 4);
    check_eq("bound_held_code", kif.key_code, 5'h08);
    sb.push_back('{1'b0, 5'h1F, -1});
    hold(16'h0000, 5);
    check_eq("bound_drain", sb.size(), 0);

    // 6. reset while '9' is held
    sb.push_back('{1'b1, 5'h09, -1});
    hold(16'h0400, 5);
    check_eq("t6_held_code", kif.key_code, 5'h09);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_eq("t6_rst_code", kif.key_code, 5'h1F);
    check_eq("t6_rst_valid", kif.key_valid, 1'b0);
    check_eq("t6_rst_row_n", kif.row_n, 4'b1110);
    check_eq("t6_rst_beep", kif.beep, 1'b0);
    keys = '0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    hold(16'h0000, 4);
    check_eq("t6_drain", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
